channel_control: RTL

CHANNEL_CONTROL -- requirements
Module: channel_control

---
 rtl/apu_pkg.sv | 30 +++
 rtl/frame_sequencer.sv | 37 +++
 rtl/channel_control.sv | 135 +++++++++++++
 3 files changed

// File: rtl/apu_pkg.sv
// Shared constants for the pulse-channel control slice: register map,
// frame-sequencer step masks and length-counter helpers.
package apu_pkg;

  localparam logic [2:0] ADDR_NRX1   = 3'd0;
  localparam logic [2:0] ADDR_NRX2   = 3'd1;
  localparam logic [2:0] ADDR_NRX3   = 3'd2;
  localparam logic [2:0] ADDR_NRX4   = 3'd3;
  localparam logic [2:0] ADDR_STATUS = 3'd4;

  // Bit n of each mask is set when entering frame step n fires that strobe.
  localparam logic [7:0] LENGTH_STEP_MASK = 8'b0101_0101;
  localparam logic [7:0] SWEEP_STEP_MASK  = 8'b0100_0100;
  localparam logic [7:0] ENV_STEP_MASK    = 8'b1000_0000;

  localparam logic [2:0] RESET_STEP = 3'd7;
  localparam logic [6:0] LENGTH_MAX = 7'd64;

  // Unreadable register bits float high on the bus.
  localparam logic [7:0] OPEN_BUS = 8'hFF;

  function automatic logic [6:0] length_load(input logic [5:0] len);
    return LENGTH_MAX - {1'b0, len};
  endfunction

  function automatic logic dac_enabled(input logic [7:0] nrx2);
    return nrx2[7:3] != 5'd0;
  endfunction

endpackage

// File: rtl/frame_sequencer.sv
// Divides the 512 Hz strobe into the 256/128/64 Hz length, sweep and
// envelope strobes using an 8-step frame counter.
module frame_sequencer
  import apu_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic tick_512,
  output logic length_tick_256,
  output logic sweep_tick_128,
  output logic env_tick_64
);

  logic [2:0] step;
  logic [2:0] next_step;

  assign next_step = step + 3'd1;

  // Strobes are registered off the step being entered, so they appear one
  // cycle after the tick and last exactly one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step            <= RESET_STEP;
      length_tick_256 <= 1'b0;
      sweep_tick_128  <= 1'b0;
      env_tick_64     <= 1'b0;
    end else begin
      length_tick_256 <= tick_512 & LENGTH_STEP_MASK[next_step];
      sweep_tick_128  <= tick_512 & SWEEP_STEP_MASK[next_step];
      env_tick_64     <= tick_512 & ENV_STEP_MASK[next_step];
      if (tick_512) begin
        step <= next_step;
      end
    end
  end

endmodule

// File: rtl/channel_control.sv
// Register interface, length counter and on/off control for one pulse
// channel, driven by the shared frame sequencer.
module channel_control
  import apu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_512,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [7:0]  wr_data,
  input  logic [2:0]  rd_addr,
  output logic [7:0]  rd_data,
  output logic        trigger,
  output logic        env_tick_64,
  output logic        sweep_tick_128,
  output logic        length_tick_256,
  output logic [3:0]  starting_volume,
  output logic        envelope_add,
  output logic [2:0]  env_period,
  output logic [1:0]  duty,
  output logic [10:0] frequency,
  output logic        dac_on,
  output logic        channel_on
);

  logic [1:0] duty_q;
  logic [7:0] nrx2;
  logic [7:0] nrx3;
  logic       length_enable;
  logic [2:0] freq_hi;
  logic [6:0] len_cnt;

  logic wr_nrx1;
  logic wr_nrx2;
  logic wr_nrx3;
  logic wr_nrx4;
  logic trig_wr;
  logic len_dec;

  frame_sequencer u_frame_sequencer (
    .clk             (clk),
    .reset           (reset),
    .tick_512        (tick_512),
    .length_tick_256 (length_tick_256),
    .sweep_tick_128  (sweep_tick_128),
    .env_tick_64     (env_tick_64)
  );

  assign wr_nrx1 = wr_en && (wr_addr == ADDR_NRX1);
  assign wr_nrx2 = wr_en && (wr_addr == ADDR_NRX2);
  assign wr_nrx3 = wr_en && (wr_addr == ADDR_NRX3);
  assign wr_nrx4 = wr_en && (wr_addr == ADDR_NRX4);
  assign trig_wr = wr_nrx4 && wr_data[7];

  // A length load or a trigger in the same cycle overrides the decrement.
  assign len_dec = length_tick_256 && length_enable && (len_cnt != 7'd0)
                   && !wr_nrx1 && !trig_wr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty_q        <= 2'd0;
      nrx2          <= 8'd0;
      nrx3          <= 8'd0;
      length_enable <= 1'b0;
      freq_hi       <= 3'd0;
    end else begin
      if (wr_nrx1) begin
        duty_q <= wr_data[7:6];
      end
      if (wr_nrx2) begin
        nrx2 <= wr_data;
      end
      if (wr_nrx3) begin
        nrx3 <= wr_data;
      end
      if (wr_nrx4) begin
        length_enable <= wr_data[6];
        freq_hi       <= wr_data[2:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_cnt <= 7'd0;
    end else if (wr_nrx1) begin
      len_cnt <= length_load(wr_data[5:0]);
    end else if (trig_wr) begin
      if (len_cnt == 7'd0) begin
        len_cnt <= LENGTH_MAX;
      end
    end else if (len_dec) begin
      len_cnt <= len_cnt - 7'd1;
    end
  end

  // NRx2 cannot change in a trigger cycle, so the stored DAC state is the
  // post-write value the trigger must copy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trigger    <= 1'b0;
      channel_on <= 1'b0;
    end else begin
      trigger <= trig_wr;
      if (trig_wr) begin
        channel_on <= dac_on;
      end else if (wr_nrx2 && !dac_enabled(wr_data)) begin
        channel_on <= 1'b0;
      end else if (len_dec && (len_cnt == 7'd1)) begin
        channel_on <= 1'b0;
      end
    end
  end

  assign dac_on          = dac_enabled(nrx2);
  assign starting_volume = nrx2[7:4];
  assign envelope_add    = nrx2[3];
  assign env_period      = nrx2[2:0];
  assign duty            = duty_q;
  assign frequency       = {freq_hi, nrx3};

  always_comb begin
    rd_data = OPEN_BUS;
    case (rd_addr)
      ADDR_NRX1:   rd_data = {duty_q, 6'h3F};
      ADDR_NRX2:   rd_data = nrx2;
      ADDR_NRX3:   rd_data = OPEN_BUS;
      ADDR_NRX4:   rd_data = {1'b1, length_enable, 6'h3F};
      ADDR_STATUS: rd_data = {7'b0, channel_on};
      default:     rd_data = OPEN_BUS;
    endcase
  end

endmodule
